row_mac_accumulator: RTL and testbench
======================================

ROW_MAC_ACCUMULATOR -- requirements
Module: row_mac_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed operand width.
REQ-002 SHALL have parameter MAX_LENGTH, default 16, maximum elements per dot product.
REQ-003 SHALL have parameter LEN_WIDTH, default $clog2(MAX_LENGTH+1), length field width.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(MAX_LENGTH), accumulator width.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as below.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-009 length  input  LEN_WIDTH  element count; sampled with start.
REQ-010 a_in  input  DATA_WIDTH  signed matrix element.
REQ-011 b_in  input  DATA_WIDTH  signed vector element.
REQ-012 in_valid  input  1  a_in/b_in pair valid.
REQ-013 in_ready  output  1  block accepts a pair this cycle.
REQ-014 result  output  ACC_WIDTH  signed dot-product result.
REQ-015 result_valid  output  1  result held valid.
REQ-016 result_ready  input  1  downstream accepts result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 near_done  output  1  high in ACCUM while remaining elements equal 3.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-020 IDLE: start=1 with length>=1 -> latch length, clear accumulator and element index, enter ACCUM next cycle.
REQ-021 IDLE: start=1 with length=0 -> clear accumulator, enter DONE directly; result=0.
REQ-022 length > MAX_LENGTH SHALL be clamped to MAX_LENGTH at latch time.
REQ-023 in_ready SHALL equal 1 only in ACCUM; a beat is accepted when in_valid & in_ready.
REQ-024 Each accepted beat: acc <= acc + sign-extended(a_in*b_in), full-precision signed product, no saturation; index increments.
REQ-025 Beat with index == latched_length-1 SHALL be the last; FSM enters DONE next cycle, index wraps to 0.
REQ-026 ACCUM with in_valid=0: no change to acc, index, or state.
REQ-027 DONE: result_valid=1, result=acc, both stable until result_ready=1.
REQ-028 DONE with result_ready=1: return to IDLE next cycle; result_valid drops same edge.
REQ-029 Latency: result_valid rises exactly 1 cycle after the last accepted beat.
REQ-030 start outside IDLE SHALL be ignored; start and result handshake in same cycle not possible (DONE->IDLE takes one cycle).
REQ-031 near_done = (state==ACCUM) & (latched_length - index == 3); never asserted for length < 3.
REQ-032 result SHALL retain last value in IDLE until next accumulator clear.

Reset
REQ-033 reset=1 at any clock edge, including mid-ACCUM or DONE: state<=IDLE, acc<=0, index<=0, latched length<=0.
REQ-034 Post-reset outputs: in_ready=0, result=0, result_valid=0, busy=0, near_done=0.
REQ-035 reset SHALL take priority over start and all handshakes.

Structure
REQ-036 Shared package mxv_pkg SHALL hold the state enum typedef (mac_state_t) and the CeilLog2 width helper.
REQ-037 Element index SHALL be a single sub-module, element_counter (enable, synchronous clear, programmable terminal count, terminal flag).
REQ-038 All outputs SHALL be driven from registers or state decode only; no combinational path input-to-output except none.

Verification
REQ-039 length=4, a={1,2,3,4}, b={5,6,7,8}, in_valid constant, result_ready=1 -> result=70, result_valid 1 cycle after beat 4, near_done high at beat 2 only.
REQ-040 length=3, a={-128,-128,127}, b={-128,127,127} (DATA_WIDTH=8) -> result=16384-16256+16129=16257, no overflow.
REQ-041 length=4 with in_valid gaps (1,0,0,1,1,0,1) and result_ready low 5 cycles -> same 70, result stable while stalled.
REQ-042 start with length=0 -> DONE next cycle, result=0, result_valid=1; length=20 -> exactly 16 beats accepted.
REQ-043 reset asserted after beat 2 of length 8 -> next cycle IDLE, all outputs 0; new start length=2, a={3,3}, b={2,2} -> result=12.
REQ-044 start pulsed during ACCUM and DONE -> ignored; latched length and result unaffected.

Source files
------------

// File: rtl/mxv_pkg.sv
// mxv_pkg: shared FSM state type and width helper for the matrix-vector MAC blocks
package mxv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } mac_state_t;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/element_counter.sv
// element_counter: element index with enable, synchronous clear and programmable wrap point
module element_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  assign at_terminal = count == terminal;

  // count up on enable, wrapping to zero after the terminal value
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= at_terminal ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/row_mac_accumulator.sv
// row_mac_accumulator: signed dot product of one matrix row with a vector, one pair per beat
module row_mac_accumulator
  import mxv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  parameter int LEN_WIDTH  = ceil_log2(MAX_LENGTH + 1),
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ceil_log2(MAX_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  near_done
);

  mac_state_t state, next_state;
  logic [LEN_WIDTH-1:0] len_q, len_clamped, index;
  logic [LEN_WIDTH:0] remaining;
  logic launch, accept, at_last;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0] acc;

  assign launch      = state == IDLE && start;
  assign accept      = state == ACCUM && in_valid;
  assign len_clamped = length > LEN_WIDTH'(MAX_LENGTH) ? LEN_WIDTH'(MAX_LENGTH) : length;
  assign product     = $signed(a_in) * $signed(b_in);
  assign remaining   = {1'b0, len_q} - {1'b0, index};

  element_counter #(.WIDTH(LEN_WIDTH)) u_index (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .enable     (accept),
    .terminal   (len_q - LEN_WIDTH'(1)),
    .count      (index),
    .at_terminal(at_last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end

  // next-state decode; a zero-length job skips straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? (length == '0 ? DONE : ACCUM) : IDLE;
      ACCUM:   next_state = accept && at_last ? DONE : ACCUM;
      DONE:    next_state = result_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  // latch the clamped length and clear the accumulator at job launch, accumulate per beat
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      acc   <= '0;
    end else if (launch) begin
      len_q <= len_clamped;
      acc   <= '0;
    end else if (accept) begin
      acc <= acc + ACC_WIDTH'(product);
    end
  end

  assign in_ready     = state == ACCUM;
  assign result_valid = state == DONE;
  assign busy         = state != IDLE;
  assign result       = acc;
  assign near_done    = state == ACCUM && remaining == (LEN_WIDTH + 1)'(3);

endmodule

// File: tb/tb_row_mac_accumulator.sv
// tb_row_mac_accumulator: directed scenario checks for the row dot-product accumulator
module tb_row_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  length = '0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic        near_done;

  int n_checks = 0;
  int n_fail = 0;

  row_mac_accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .length      (length),
    .a_in        (a_in),
    .b_in        (b_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy),
    .near_done   (near_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int len);
    start = 1'b1;
    length = 5'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (result !== 20'd0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (near_done !== 1'b0) begin n_fail++; $display("FAIL reset_near_done got=%b exp=0", near_done); end
  endtask

  task automatic test_basic();
    int av[4] = '{1, 2, 3, 4};
    int bv[4] = '{5, 6, 7, 8};
    result_ready = 1'b1;
    launch(4);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_accum_entry got in_ready=%b busy=%b exp=1,1", in_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      a_in = 8'(av[i]);
      b_in = 8'(bv[i]);
      in_valid = 1'b1;
      n_checks++; if (near_done !== (i == 1)) begin n_fail++; $display("FAIL basic_near_done beat%0d got=%b exp=%b", i + 1, near_done, i == 1); end
      if (i == 3) begin
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", result_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got=%b exp=1", result_valid); end
    n_checks++; if (result !== 20'd70) begin n_fail++; $display("FAIL basic_result got=%0d exp=70", result); end
    tick();
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle got valid=%b busy=%b exp=0,0", result_valid, busy); end
    n_checks++; if (result !== 20'd70) begin n_fail++; $display("FAIL basic_result_retained got=%0d exp=70", result); end
  endtask

  task automatic test_extremes();
    int av[3] = '{-128, -128, 127};
    int bv[3] = '{-128, 127, 127};
    result_ready = 1'b1;
    launch(3);
    for (int i = 0; i < 3; i++) begin
      a_in = 8'(av[i]);
      b_in = 8'(bv[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL extremes_valid got=%b exp=1", result_valid); end
    n_checks++; if (result !== 20'd16257) begin n_fail++; $display("FAIL extremes_result got=%0d exp=16257", result); end
    tick();
  endtask

  task automatic test_gaps();
    int vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int k = 0;
    result_ready = 1'b0;
    launch(4);
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i][0];
      a_in = in_valid ? 8'(k + 1) : 8'd99;
      b_in = in_valid ? 8'(k + 5) : 8'd99;
      if (in_valid) k++;
      if (i == 2) begin
        n_checks++; if (in_ready !== 1'b1 || result_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_wait got in_ready=%b valid=%b exp=1,0", in_ready, result_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      n_checks++; if (result_valid !== 1'b1 || result !== 20'd70) begin n_fail++; $display("FAIL gaps_stall%0d got valid=%b result=%0d exp=1,70", s, result_valid, result); end
      tick();
    end
    result_ready = 1'b1;
    tick();
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_release got=%b exp=0", result_valid); end
  endtask

  task automatic test_zero_length();
    result_ready = 1'b0;
    launch(0);
    n_checks++; if (result_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_done got valid=%b busy=%b exp=1,1", result_valid, busy); end
    n_checks++; if (result !== 20'd0) begin n_fail++; $display("FAIL zero_result got=%0d exp=0", result); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got=%b exp=0", in_ready); end
    result_ready = 1'b1;
    tick();
  endtask

  task automatic test_clamp();
    int beats = 0;
    result_ready = 1'b0;
    launch(20);
    a_in = 8'd1;
    b_in = 8'd1;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !result_valid; c++) begin
      if (in_ready && in_valid) beats++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL clamp_timeout got valid=%b exp=1", result_valid); end
    n_checks++; if (beats != 16) begin n_fail++; $display("FAIL clamp_beats got=%0d exp=16", beats); end
    n_checks++; if (result !== 20'd16) begin n_fail++; $display("FAIL clamp_result got=%0d exp=16", result); end
    result_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    result_ready = 1'b1;
    launch(8);
    a_in = 8'd5;
    b_in = 8'd5;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_state got busy=%b in_ready=%b exp=0,0", busy, in_ready); end
    n_checks++; if (result !== 20'd0 || result_valid !== 1'b0 || near_done !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got result=%0d valid=%b near=%b exp=0,0,0", result, result_valid, near_done); end
    launch(2);
    a_in = 8'd3;
    b_in = 8'd2;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    n_checks++; if (result_valid !== 1'b1 || result !== 20'd12) begin n_fail++; $display("FAIL midreset_restart got valid=%b result=%0d exp=1,12", result_valid, result); end
    tick();
  endtask

  task automatic test_start_ignored();
    result_ready = 1'b0;
    launch(4);
    for (int i = 0; i < 4; i++) begin
      a_in = 8'(i + 1);
      b_in = 8'(i + 5);
      in_valid = 1'b1;
      start = i < 2;
      length = 5'd2;
      if (i == 3) begin
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_accum_start got valid=%b exp=0 before beat 4", result_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1;
    length = 5'd1;
    n_checks++; if (result_valid !== 1'b1 || result !== 20'd70) begin n_fail++; $display("FAIL ignore_result got valid=%b result=%0d exp=1,70", result_valid, result); end
    tick();
    tick();
    n_checks++; if (result_valid !== 1'b1 || result !== 20'd70) begin n_fail++; $display("FAIL ignore_done_start got valid=%b result=%0d exp=1,70", result_valid, result); end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || result !== 20'd70) begin n_fail++; $display("FAIL ignore_idle got busy=%b result=%0d exp=0,70", busy, result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_gaps();
    test_zero_length();
    test_clamp();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
